// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle core's execute-stage helpers.
// Holds the multiply/divide op codes, FSM state encodings and default width.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected in a final FIX cycle.
//
// state   | meaning
// IDLE    | waiting for start; mthi/mtlo write hi/lo directly
// CALC    | one multiply/divide iteration per clock, WIDTH iterations
// FIX     | sign correction, hi/lo write, one-cycle done
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return '0 - v;
    endfunction

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = signed_op && op_a[WIDTH-1];
        b_neg     = signed_op && op_b[WIDTH-1];
        a_mag     = a_neg ? neg_w(op_a) : op_a;
        b_mag     = b_neg ? neg_w(op_b) : op_b;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, remaining dividend bits / quotient bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (div_diff[WIDTH])
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod = neg_q ? ('0 - acc) : acc;
        if (is_div) begin
            res_lo = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            res_hi = neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    assign busy = (state != MD_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                acc    <= {{WIDTH{1'b0}}, b_mag};
                                opnd   <= a_mag;
                                is_div <= 1'b0;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                cnt    <= '0;
                                state  <= MD_CALC;
                            end
                            MD_DIV, MD_DIVU: begin
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                opnd   <= b_mag;
                                is_div <= 1'b1;
                                // Divide by zero keeps the all-ones quotient unsigned.
                                neg_q  <= (a_neg ^ b_neg) && (op_b != '0);
                                neg_r  <= a_neg;
                                cnt    <= '0;
                                state  <= MD_CALC;
                            end
                            MD_MTHI: hi <= op_a;
                            MD_MTLO: lo <= op_a;
                            default: ;
                        endcase
                    end
                end
                MD_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1))
                        state <= MD_FIX;
                end
                MD_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected hi/lo queued at issue, checked by
// a negedge monitor on each done pulse together with latency and busy length.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_run = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", W'(done), '0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    check({e.name, "_latency"}, W'(cyc - e.t0), W'(LAT));
                    check({e.name, "_busy_cycles"}, W'(busy_run), W'(LAT));
                end
                busy_run = 0;
            end
            if (busy) busy_run++;
        end
    end

    task automatic run_md(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        exp_t e;
        @(negedge clk);
        e.name = name;
        e.hi   = ehi;
        e.lo   = elo;
        e.t0   = cyc + 1;
        sb.push_back(e);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < LAT + 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check({name, "_timeout"}, W'(sb.size()), '0);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);

        run_md("mult_neg3x7",  MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("multu_max",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("mult_m1xm1",   MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_md("div_neg7by2",  MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_7byneg2",  MD_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu_7by2",    MD_DIVU,  32'd7,        32'd2,        32'h0000_0001, 32'h0000_0003);
        run_md("div_overflow", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_md("div_neg7by0",  MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_md("divu_by0",     MD_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF);

        // mthi then mtlo on back-to-back cycles
        @(negedge clk);
        start = 1'b1;
        op    = MD_MTHI;
        op_a  = 32'hA5A5_A5A5;
        @(negedge clk);
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        check("mthi_busy", W'(busy), '0);
        check("mthi_done", W'(done), '0);
        op   = MD_MTLO;
        op_a = 32'h5A5A_5A5A;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", lo, 32'h5A5A_5A5A);
        check("mtlo_hi_kept", hi, 32'hA5A5_A5A5);
        check("mtlo_busy", W'(busy), '0);
        check("mtlo_done", W'(done), '0);

        // reserved op code does nothing
        start = 1'b1;
        op    = 3'd6;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("op6_busy", W'(busy), '0);
        check("op6_hi", hi, 32'hA5A5_A5A5);
        check("op6_lo", lo, 32'h5A5A_5A5A);

        // mult, ignored mthi while busy, then reset mid-operation
        start = 1'b1;
        op    = MD_MULT;
        op_a  = 32'd3;
        op_b  = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start = 1'b1;
        op    = MD_MTHI;
        op_a  = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        check("busy_mthi_ignored_hi", hi, 32'hA5A5_A5A5);
        check("busy_mthi_busy", W'(busy), 32'd1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", W'(busy), '0);
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 10) @(negedge clk);
        check("abort_no_done", W'(done), '0);
        check("abort_idle_busy", W'(busy), '0);

        run_md("multu_after_rst", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);

        check("scoreboard_empty", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
